spiflash_line_cache: RTL and testbench

- Direct-mapped, read-only line cache between the PicoRV32 instruction/data bus and the SPI flash memory controller (spimemio). Downstream port connects to the controller's valid/ready/addr/rdata.
- Hits return in one cycle. Misses refill a whole line as consecutive word reads, so the controller's sequential-continuation fast path is used.
- A flush input invalidates all lines. It is pulsed by the SoC whenever the flash config register is written.

---
 rtl/spiflash_line_cache.sv | 180 ++++++++++++++++++
 tb/tb_spiflash_line_cache.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spiflash_line_cache.sv
// Direct-mapped, read-only line cache between the PicoRV32 memory bus and spimemio.
// Misses refill a whole line with back-to-back word reads so the controller can stream them.
module spiflash_line_cache #(
  parameter int LINES_LOG2 = 3,
  parameter int WORDS_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        cpu_valid,
  output logic        cpu_ready,
  input  logic [23:0] cpu_addr,
  output logic [31:0] cpu_rdata,
  output logic        mem_valid,
  output logic [23:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int LINES   = 1 << LINES_LOG2;
  localparam int WORDS   = 1 << WORDS_LOG2;
  localparam int IDX_W   = LINES_LOG2 + WORDS_LOG2;
  localparam int TAG_LSB = IDX_W + 2;
  localparam int TAG_W   = 24 - TAG_LSB;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RESP
  } state_e;

  state_e state_q, state_d;

  logic [LINES-1:0]      valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [31:0]           data_q [LINES*WORDS];

  logic [TAG_W-1:0]      req_tag_q,   req_tag_d;
  logic [LINES_LOG2-1:0] req_index_q, req_index_d;
  logic [WORDS_LOG2-1:0] req_word_q,  req_word_d;
  logic [WORDS_LOG2-1:0] fill_cnt_q,  fill_cnt_d;

  logic        cpu_ready_q, cpu_ready_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic        mem_valid_q, mem_valid_d;
  logic [23:0] mem_addr_q,  mem_addr_d;

  logic data_we, tag_we;

  // Address split of the incoming request; the byte offset is never used.
  logic [WORDS_LOG2-1:0] in_word;
  logic [LINES_LOG2-1:0] in_index;
  logic [TAG_W-1:0]      in_tag;
  logic                  unused_addr_bits;

  assign in_word          = cpu_addr[WORDS_LOG2+1:2];
  assign in_index         = cpu_addr[TAG_LSB-1:WORDS_LOG2+2];
  assign in_tag           = cpu_addr[23:TAG_LSB];
  assign unused_addr_bits = ^cpu_addr[1:0];

  logic new_req, hit, beat, last_beat;

  // A cycle that just carried cpu_ready is never a fresh request.
  assign new_req   = cpu_valid && !cpu_ready_q && !flush;
  assign hit       = valid_q[in_index] && (tag_q[in_index] == in_tag);
  assign beat      = mem_valid_q && mem_ready;
  assign last_beat = beat && (&fill_cnt_q);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (new_req && !hit) state_d = S_FILL;
      S_FILL:  if (flush) state_d = S_IDLE;
               else if (last_beat) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    valid_d     = valid_q;
    cpu_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    mem_valid_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    fill_cnt_d  = fill_cnt_q;
    req_tag_d   = req_tag_q;
    req_index_d = req_index_q;
    req_word_d  = req_word_q;
    data_we     = 1'b0;
    tag_we      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (new_req) begin
          if (hit) begin
            cpu_ready_d = 1'b1;
            cpu_rdata_d = data_q[{in_index, in_word}];
          end else begin
            req_tag_d         = in_tag;
            req_index_d       = in_index;
            req_word_d        = in_word;
            mem_addr_d        = {in_tag, in_index, {(WORDS_LOG2+2){1'b0}}};
            fill_cnt_d        = '0;
            valid_d[in_index] = 1'b0;
          end
        end
      end
      S_FILL: begin
        // mem_valid rises one cycle after FILL entry and falls on the last beat or a flush.
        if (!flush) begin
          mem_valid_d = 1'b1;
          if (beat) begin
            data_we    = 1'b1;
            fill_cnt_d = fill_cnt_q + WORDS_LOG2'(1);
            mem_addr_d = mem_addr_q + 24'd4;
            if (last_beat) begin
              mem_valid_d          = 1'b0;
              valid_d[req_index_q] = 1'b1;
              tag_we               = 1'b1;
            end
          end
        end
      end
      S_RESP: begin
        cpu_ready_d = cpu_valid;
        if (cpu_valid) cpu_rdata_d = data_q[{req_index_q, req_word_q}];
      end
      default: ;
    endcase

    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= '0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      fill_cnt_q  <= '0;
      req_tag_q   <= '0;
      req_index_q <= '0;
      req_word_q  <= '0;
    end else begin
      valid_q     <= valid_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      fill_cnt_q  <= fill_cnt_d;
      req_tag_q   <= req_tag_d;
      req_index_q <= req_index_d;
      req_word_q  <= req_word_d;
    end
  end

  // NOTE: tag and data arrays are not reset; the valid bits alone decide whether they are trusted.
  always_ff @(posedge clk) begin
    if (data_we) data_q[{req_index_q, fill_cnt_q}] <= mem_rdata;
    if (tag_we)  tag_q[req_index_q] <= req_tag_q;
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_spiflash_line_cache.sv
// Randomised bench for spiflash_line_cache: stub flash returns addr^0xA5A5A5A5 with configurable
// ready gaps; a line-presence model predicts hit/miss, latency, refill addresses and data.
module tb_spiflash_line_cache;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        cpu_valid = 1'b0;
  logic [23:0] cpu_addr = '0;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        mem_valid;
  logic [23:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spiflash_line_cache dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .cpu_valid (cpu_valid),
    .cpu_ready (cpu_ready),
    .cpu_addr  (cpu_addr),
    .cpu_rdata (cpu_rdata),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  // Flash stub: 0 = ready every cycle, 1 = fixed 3-cycle gaps, 2 = random 0..3 gaps.
  int         gap_mode = 0;
  logic [2:0] gap_q = '0;

  assign mem_ready = mem_valid && (gap_q == 3'd0);
  assign mem_rdata = {8'h00, mem_addr} ^ 32'hA5A5A5A5;

  always @(posedge clk) begin
    if (mem_valid && mem_ready) begin
      case (gap_mode)
        1:       gap_q <= 3'd3;
        2:       gap_q <= 3'($urandom_range(0, 3));
        default: gap_q <= 3'd0;
      endcase
    end else if (gap_q != 3'd0) begin
      gap_q <= gap_q - 3'd1;
    end
  end

  // Reference model: which (index, tag) lines are present, for 8 lines of 16 bytes.
  bit model_valid [8];
  int model_tag   [8];

  function automatic int idx_of(input logic [23:0] a);
    return (int'(a) / 16) % 8;
  endfunction

  function automatic int tag_of(input logic [23:0] a);
    return int'(a) / 128;
  endfunction

  function automatic logic [31:0] flash_word(input logic [23:0] a);
    return {8'h00, (a / 24'd4) * 24'd4} ^ 32'hA5A5A5A5;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) model_valid[i] = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // mode 0: plain read; 1: flush in the request cycle; 2: flush on the 2nd fill beat.
  task automatic read(input logic [23:0] a, input int mode);
    bit          got_r, exp_hit, prev_stall;
    int          lat, beats, waits, flush_at;
    logic [23:0] base, prev_addr;
    logic [31:0] data;
    base = (a / 24'd16) * 24'd16;
    if (mode == 1) model_clear();
    exp_hit = model_valid[idx_of(a)] && (model_tag[idx_of(a)] == tag_of(a));
    @(posedge clk); #1;
    cpu_valid = 1'b1;
    cpu_addr  = a;
    flush     = (mode == 1);
    got_r = 1'b0; lat = 0; beats = 0; waits = 0; flush_at = -1;
    prev_stall = 1'b0; prev_addr = '0; data = '0;
    for (int k = 0; k < 300 && !got_r; k++) begin
      @(negedge clk);
      if (flush_at >= 0 && k == flush_at + 1) begin
        check("abort_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("abort_no_ready", {31'd0, cpu_ready}, 32'd0);
      end
      if (mode == 1 && k == 1) check("flush_req_no_ready", {31'd0, cpu_ready}, 32'd0);
      if (cpu_ready) begin
        got_r = 1'b1;
        lat   = k;
        data  = cpu_rdata;
      end else if (mem_valid && !flush) begin
        if (prev_stall) check("addr_stable", {8'h00, mem_addr}, {8'h00, prev_addr});
        if (mem_ready) begin
          check("beat_addr", {8'h00, mem_addr}, {8'h00, base + 24'(4 * beats)});
          beats++;
        end else begin
          waits++;
        end
      end
      prev_stall = mem_valid && !mem_ready;
      prev_addr  = mem_addr;
      if (!got_r) begin
        @(posedge clk); #1;
        flush = 1'b0;
        if (mode == 2 && flush_at < 0 && beats == 1) begin
          flush    = 1'b1;
          flush_at = k + 1;
          model_clear();
          beats = 0;
          waits = 0;
        end
      end
    end
    flush = 1'b0;
    check("got_ready", {31'd0, got_r}, 32'd1);
    if (got_r) begin
      check("rdata", data, flash_word(a));
      if (exp_hit) begin
        check("hit_latency", 32'(lat), 32'd1);
        check("hit_no_fill", 32'(beats), 32'd0);
      end else begin
        check("fill_beats", 32'(beats), 32'd4);
        if (mode != 2) check("miss_latency", 32'(lat), 32'((mode == 1 ? 1 : 0) + 3 + waits + 4));
      end
      model_valid[idx_of(a)] = 1'b1;
      model_tag[idx_of(a)]   = tag_of(a);
    end
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    @(negedge clk);
    check("no_back2back", {31'd0, cpu_ready}, 32'd0);
    @(negedge clk);
    check("no_spurious_fill", {31'd0, mem_valid}, 32'd0);
  endtask

  // Wait (bounded) until the first fill beat of a request to address a is seen.
  task automatic wait_first_beat(output bit found);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      if (mem_valid && mem_ready) found = 1'b1;
    end
    check("beat_seen", {31'd0, found}, 32'd1);
  endtask

  task automatic drop_mid_fill(input logic [23:0] a);
    bit found, saw_ready;
    @(posedge clk); #1;
    cpu_valid = 1'b1;
    cpu_addr  = a;
    wait_first_beat(found);
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    saw_ready = 1'b0;
    repeat (30) begin
      @(negedge clk);
      saw_ready |= cpu_ready;
    end
    check("drop_no_ready", {31'd0, saw_ready}, 32'd0);
    check("drop_mem_idle", {31'd0, mem_valid}, 32'd0);
    model_valid[idx_of(a)] = 1'b1;
    model_tag[idx_of(a)]   = tag_of(a);
  endtask

  task automatic reset_mid_fill(input logic [23:0] a);
    bit found;
    @(posedge clk); #1;
    cpu_valid = 1'b1;
    cpu_addr  = a;
    wait_first_beat(found);
    @(posedge clk); #1;
    reset     = 1'b1;
    cpu_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_fill_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_fill_mem_addr", {8'h00, mem_addr}, 32'd0);
    check("rst_fill_cpu_ready", {31'd0, cpu_ready}, 32'd0);
    check("rst_fill_cpu_rdata", cpu_rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
    check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_mem_addr", {8'h00, mem_addr}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed scenarios.
    read(24'h000104, 0);
    read(24'h000108, 0);
    read(24'h000180, 0);
    read(24'h000100, 0);
    gap_mode = 1;
    read(24'h000204, 0);
    read(24'h00020C, 0);
    gap_mode = 0;
    read(24'h000300, 2);
    read(24'h000304, 1);
    drop_mid_fill(24'h000400);
    read(24'h00040C, 0);
    reset_mid_fill(24'h000584);
    read(24'h000100, 0);

    // Random reads over a small window so lines get reused, evicted and flushed.
    for (int i = 0; i < 60; i++) begin
      gap_mode = int'($urandom_range(0, 2));
      read(24'($urandom_range(0, 'h3FF)), ($urandom_range(0, 9) == 0) ? 2 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
